// File: rtl/alu_sequencer_p.sv
// alu_sequencer_p: steps a program counter through an external instruction memory,
// executes one ALU op per instruction and hands each result out over valid/ready.
module alu_sequencer_p #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 6,
  parameter int LOOP   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      last_addr,
  output logic [ADDR_W-1:0]      pc,
  input  logic [2*WIDTH+2:0]     instr,
  output logic [WIDTH-1:0]       res_data,
  output logic [3:0]             res_flags,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   last_q;
  logic [WIDTH-1:0]    res_data_q;
  logic [3:0]          res_flags_q;
  logic                res_valid_q;
  logic                busy_q;
  logic                done_q;

  logic [2:0]          op;
  logic [WIDTH-1:0]    opa;
  logic [WIDTH-1:0]    opb;
  logic [WIDTH-1:0]    opb_eff;
  logic                is_sub;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    res_data_d;
  logic [3:0]          res_flags_d;
  logic                carry;
  logic                ovf;

  // Subtraction reuses the adder as A + ~B + 1, so carry-out means "no borrow".
  always_comb begin
    op      = instr[2*WIDTH+2 -: 3];
    opa     = instr[2*WIDTH-1 -: WIDTH];
    opb     = instr[WIDTH-1:0];
    is_sub  = (op == 3'b001);
    opb_eff = is_sub ? ~opb : opb;
    sum     = {1'b0, opa} + {1'b0, opb_eff} + {{WIDTH{1'b0}}, is_sub};
    carry   = 1'b0;
    ovf     = 1'b0;
    res_data_d = '0;
    case (op)
      3'b000, 3'b001: begin
        res_data_d = sum[WIDTH-1:0];
        carry      = sum[WIDTH];
        ovf        = (opa[WIDTH-1] == opb_eff[WIDTH-1]) &&
                     (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      // Shifting by the full B value yields zero once B reaches WIDTH.
      3'b010:  res_data_d = opa << opb;
      3'b011:  res_data_d = opa >> opb;
      3'b100:  res_data_d = opa & opb;
      3'b101:  res_data_d = opa | opb;
      3'b110:  res_data_d = opa ^ opb;
      default: res_data_d = ~opa;
    endcase
    res_flags_d = {res_data_d[WIDTH-1], (res_data_d == '0), carry, ovf};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      last_q      <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= S_IDLE;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            pc_q    <= '0;
            last_q  <= last_addr;
            busy_q  <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data_q  <= res_data_d;
          res_flags_q <= res_flags_d;
          res_valid_q <= 1'b1;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (pc_q != last_q) begin
              pc_q    <= pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
              state_q <= S_EXEC;
            end else if (LOOP != 0) begin
              pc_q    <= '0;
              state_q <= S_EXEC;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc        = pc_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_sequencer_p.sv
// Bench for alu_sequencer_p: a LOOP=0 and a LOOP=1 instance share one instruction memory.
module tb_alu_sequencer_p;

  logic        clock;
  logic        reset;
  logic        start0, abort0, ready0;
  logic [5:0]  last0, pc0;
  logic [18:0] instr0;
  logic [7:0]  data0;
  logic [3:0]  flags0;
  logic        valid0, busy0, done0;
  logic        start1, abort1, ready1;
  logic [5:0]  last1, pc1;
  logic [18:0] instr1;
  logic [7:0]  data1;
  logic [3:0]  flags1;
  logic        valid1, busy1, done1;

  logic [18:0] mem [0:63];
  int n_cmp = 0;
  int n_err = 0;

  assign instr0 = mem[pc0];
  assign instr1 = mem[pc1];

  alu_sequencer_p #(.WIDTH(8), .ADDR_W(6), .LOOP(0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .abort(abort0), .last_addr(last0),
    .pc(pc0), .instr(instr0), .res_data(data0), .res_flags(flags0), .res_valid(valid0),
    .res_ready(ready0), .busy(busy0), .done(done0));

  alu_sequencer_p #(.WIDTH(8), .ADDR_W(6), .LOOP(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .abort(abort1), .last_addr(last1),
    .pc(pc1), .instr(instr1), .res_data(data1), .res_flags(flags1), .res_valid(valid1),
    .res_ready(ready1), .busy(busy1), .done(done1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference: {result[7:0], N, Z, C, V} from integer arithmetic on the operands.
  function automatic logic [11:0] ref_model(input logic [18:0] ins);
    int op, a, b, r, s, sd;
    logic c, v;
    logic [7:0] rb;
    op = int'(ins[18:16]); a = int'(ins[15:8]); b = int'(ins[7:0]);
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      0: begin s = a + b; r = s % 256; c = (s >= 256);
               sd = sgn(a) + sgn(b); v = (sd > 127) || (sd < -128); end
      1: begin s = a + (255 - b) + 1; r = s % 256; c = (s >= 256);
               sd = sgn(a) - sgn(b); v = (sd > 127) || (sd < -128); end
      2: r = (b >= 8) ? 0 : ((a << b) % 256);
      3: r = (b >= 8) ? 0 : (a >> b);
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = 255 - a;
    endcase
    rb = 8'(r);
    return {rb, (r >= 128), (r == 0), c, v};
  endfunction

  function automatic logic [18:0] mk(input int op, input int a, input int b);
    return {3'(op), 8'(a), 8'(b)};
  endfunction

  function automatic logic [18:0] rand_instr();
    int op;
    op = $urandom_range(0, 7);
    if (op == 2 || op == 3) return mk(op, $urandom_range(0, 255), $urandom_range(0, 11));
    return mk(op, $urandom_range(0, 255), $urandom_range(0, 255));
  endfunction

  task automatic wait_valid0(input string tag);
    int k;
    k = 0;
    while (valid0 !== 1'b1 && k < 20) begin @(negedge clock); k++; end
    n_cmp++;
    if (valid0 !== 1'b1) begin
      n_err++; $display("FAIL %s_valid_timeout: res_valid=%b after 20 cycles, required 1", tag, valid0);
    end
  endtask

  task automatic wait_idle0(input string tag);
    int k;
    k = 0;
    while (busy0 !== 1'b0 && k < 20) begin @(negedge clock); k++; end
    n_cmp++;
    if (busy0 !== 1'b0) begin
      n_err++; $display("FAIL %s_idle_timeout: busy=%b after 20 cycles, required 0", tag, busy0);
    end
  endtask

  task automatic pulse_start0();
    @(negedge clock); start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (pc0 !== 6'd0)    begin n_err++; $display("FAIL reset_pc: got %h, required 00", pc0); end
    n_cmp++; if (data0 !== 8'd0)  begin n_err++; $display("FAIL reset_data: got %h, required 00", data0); end
    n_cmp++; if (flags0 !== 4'd0) begin n_err++; $display("FAIL reset_flags: got %b, required 0000", flags0); end
    n_cmp++; if ({valid0, busy0, done0} !== 3'b000)
      begin n_err++; $display("FAIL reset_ctrl: valid/busy/done=%b, required 000", {valid0, busy0, done0}); end
    n_cmp++; if ({valid1, busy1, done1, pc1} !== 9'd0)
      begin n_err++; $display("FAIL reset_dut1: valid/busy/done/pc=%b, required 0", {valid1, busy1, done1, pc1}); end
  endtask

  task automatic test_add_done();
    logic [11:0] e;
    mem[0] = mk(0, 8'hFF, 8'h01); last0 = 6'd0; ready0 = 1'b1;
    e = ref_model(mem[0]);
    pulse_start0();
    n_cmp++; if ({busy0, valid0, pc0} !== {1'b1, 1'b0, 6'd0})
      begin n_err++; $display("FAIL add_exec: busy/valid/pc=%b, required 1 0 000000", {busy0, valid0, pc0}); end
    @(negedge clock);
    n_cmp++; if ({valid0, data0, flags0} !== {1'b1, e})
      begin n_err++; $display("FAIL add_result: valid/data/flags=%h, required %h", {valid0, data0, flags0}, {1'b1, e}); end
    @(negedge clock);
    n_cmp++; if ({done0, busy0, valid0} !== 3'b110)
      begin n_err++; $display("FAIL add_done_pulse: done/busy/valid=%b, required 110", {done0, busy0, valid0}); end
    @(negedge clock);
    n_cmp++; if ({done0, busy0} !== 2'b00)
      begin n_err++; $display("FAIL add_done_end: done/busy=%b, required 00", {done0, busy0}); end
  endtask

  task automatic test_single_ops();
    logic [18:0] vec [0:13];
    logic [11:0] e;
    vec[0] = mk(1, 8'h80, 8'h01); vec[1] = mk(1, 8'h01, 8'h02);
    vec[2] = mk(2, 8'h81, 8'h09); vec[3] = mk(3, 8'h80, 8'h03);
    vec[4] = mk(2, 8'h03, 8'h01); vec[5] = mk(7, 8'h5A, 8'h00);
    for (int i = 6; i < 14; i++) vec[i] = rand_instr();
    ready0 = 1'b1; last0 = 6'd0;
    for (int i = 0; i < 14; i++) begin
      mem[0] = vec[i];
      e = ref_model(vec[i]);
      pulse_start0();
      wait_valid0("single_op");
      n_cmp++; if ({data0, flags0} !== e)
        begin n_err++; $display("FAIL single_op[%0d] instr=%h: data/flags=%h, required %h", i, vec[i], {data0, flags0}, e); end
      wait_idle0("single_op");
    end
  endtask

  task automatic test_stall();
    logic [11:0] e0, e1;
    mem[0] = rand_instr(); mem[1] = rand_instr();
    e0 = ref_model(mem[0]); e1 = ref_model(mem[1]);
    last0 = 6'd1; ready0 = 1'b0;
    pulse_start0();
    wait_valid0("stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_cmp++; if ({valid0, pc0, data0, flags0} !== {1'b1, 6'd0, e0})
        begin n_err++; $display("FAIL stall_hold[%0d]: valid/pc/data/flags=%h, required %h", i, {valid0, pc0, data0, flags0}, {1'b1, 6'd0, e0}); end
    end
    ready0 = 1'b1;
    @(negedge clock);
    n_cmp++; if ({valid0, pc0} !== {1'b0, 6'd1})
      begin n_err++; $display("FAIL stall_after_hs: valid/pc=%h, required %h", {valid0, pc0}, {1'b0, 6'd1}); end
    @(negedge clock);
    n_cmp++; if ({valid0, data0, flags0} !== {1'b1, e1})
      begin n_err++; $display("FAIL stall_next: valid/data/flags=%h, required %h", {valid0, data0, flags0}, {1'b1, e1}); end
    wait_idle0("stall");
  endtask

  // Random ready pattern with stray start pulses that must be ignored mid-run.
  task automatic test_back_to_back();
    int n, idx, k;
    logic [11:0] e;
    n = 12;
    for (int i = 0; i < n; i++) mem[i] = rand_instr();
    last0 = 6'(n - 1); ready0 = 1'b0;
    pulse_start0();
    idx = 0; k = 0;
    while (idx < n && k < 400) begin
      if (valid0 === 1'b1) begin
        e = ref_model(mem[idx]);
        n_cmp++; if ({pc0, data0, flags0} !== {6'(idx), e})
          begin n_err++; $display("FAIL b2b[%0d]: pc/data/flags=%h, required %h", idx, {pc0, data0, flags0}, {6'(idx), e}); end
      end
      start0 = (idx < n - 1) && ($urandom_range(0, 3) == 0);
      ready0 = ($urandom_range(0, 1) == 1);
      if (valid0 === 1'b1 && ready0) idx++;
      @(negedge clock); k++;
    end
    start0 = 1'b0;
    n_cmp++; if (idx != n) begin n_err++; $display("FAIL b2b_count: got %0d results, required %0d", idx, n); end
    n_cmp++; if ({done0, busy0} !== 2'b11)
      begin n_err++; $display("FAIL b2b_done: done/busy=%b, required 11", {done0, busy0}); end
    @(negedge clock);
    n_cmp++; if ({done0, busy0} !== 2'b00)
      begin n_err++; $display("FAIL b2b_end: done/busy=%b, required 00", {done0, busy0}); end
  endtask

  task automatic test_loop();
    int pcs [0:4];
    int got, k;
    logic [11:0] e;
    bit saw_done;
    pcs[0] = 0; pcs[1] = 1; pcs[2] = 2; pcs[3] = 0; pcs[4] = 1;
    for (int i = 0; i < 3; i++) mem[i] = rand_instr();
    last1 = 6'd2; ready1 = 1'b1;
    @(negedge clock); start1 = 1'b1;
    @(negedge clock); start1 = 1'b0;
    got = 0; k = 0; saw_done = 1'b0;
    while (got < 5 && k < 40) begin
      if (done1 === 1'b1) saw_done = 1'b1;
      if (valid1 === 1'b1) begin
        e = ref_model(mem[pcs[got]]);
        n_cmp++; if ({pc1, data1, flags1} !== {6'(pcs[got]), e})
          begin n_err++; $display("FAIL loop[%0d]: pc/data/flags=%h, required %h", got, {pc1, data1, flags1}, {6'(pcs[got]), e}); end
        got++;
      end
      @(negedge clock); k++;
    end
    n_cmp++; if (got != 5 || saw_done)
      begin n_err++; $display("FAIL loop_run: results=%0d done_seen=%b, required 5 and 0", got, saw_done); end
    abort1 = 1'b1;
    @(negedge clock); abort1 = 1'b0;
    n_cmp++; if ({busy1, valid1, done1} !== 3'b000)
      begin n_err++; $display("FAIL loop_abort: busy/valid/done=%b, required 000", {busy1, valid1, done1}); end
  endtask

  task automatic test_abort();
    logic [11:0] e1;
    bit saw_done;
    for (int i = 0; i < 4; i++) mem[i] = rand_instr();
    e1 = ref_model(mem[1]);
    last0 = 6'd3; ready0 = 1'b0;
    pulse_start0();
    wait_valid0("abort");
    ready0 = 1'b1;
    @(negedge clock); ready0 = 1'b0;
    @(negedge clock);
    n_cmp++; if ({valid0, pc0} !== {1'b1, 6'd1})
      begin n_err++; $display("FAIL abort_pre: valid/pc=%h, required %h", {valid0, pc0}, {1'b1, 6'd1}); end
    abort0 = 1'b1;
    @(negedge clock); abort0 = 1'b0;
    n_cmp++; if ({valid0, busy0, done0, pc0, data0, flags0} !== {3'b000, 6'd1, e1})
      begin n_err++; $display("FAIL abort_state: valid/busy/done/pc/data/flags=%h, required %h",
                              {valid0, busy0, done0, pc0, data0, flags0}, {3'b000, 6'd1, e1}); end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clock); if (done0 === 1'b1 || busy0 === 1'b1) saw_done = 1'b1; end
    n_cmp++; if (saw_done) begin n_err++; $display("FAIL abort_quiet: activity seen after abort, required none"); end
    abort0 = 1'b1; start0 = 1'b1;
    @(negedge clock); abort0 = 1'b0; start0 = 1'b0;
    @(negedge clock);
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL abort_start: busy=%b, required 0", busy0); end
  endtask

  task automatic test_async_reset();
    int k;
    logic [11:0] e;
    mem[0] = rand_instr(); mem[1] = mk(0, 1, 1); mem[2] = rand_instr(); mem[3] = rand_instr();
    last0 = 6'd3; ready0 = 1'b1;
    pulse_start0();
    k = 0;
    while (!(valid0 === 1'b1 && pc0 === 6'd1) && k < 20) begin @(negedge clock); k++; end
    @(negedge clock);
    n_cmp++; if ({busy0, valid0, pc0, data0} !== {2'b10, 6'd2, 8'd2})
      begin n_err++; $display("FAIL arst_pre: busy/valid/pc/data=%h, required %h", {busy0, valid0, pc0, data0}, {2'b10, 6'd2, 8'd2}); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({pc0, data0, flags0, valid0, busy0, done0} !== 21'd0)
      begin n_err++; $display("FAIL arst_now: pc/data/flags/valid/busy/done=%h, required 0", {pc0, data0, flags0, valid0, busy0, done0}); end
    @(negedge clock); reset = 1'b0;
    mem[0] = rand_instr(); last0 = 6'd0;
    e = ref_model(mem[0]);
    pulse_start0();
    n_cmp++; if ({busy0, pc0} !== {1'b1, 6'd0})
      begin n_err++; $display("FAIL arst_restart: busy/pc=%h, required %h", {busy0, pc0}, {1'b1, 6'd0}); end
    wait_valid0("arst");
    n_cmp++; if ({data0, flags0} !== e)
      begin n_err++; $display("FAIL arst_result: data/flags=%h, required %h", {data0, flags0}, e); end
    wait_idle0("arst");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b0; last0 = '0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b0; last1 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_add_done();
    test_single_ops();
    test_stall();
    test_back_to_back();
    test_loop();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer_p.md
Name: alu_sequencer_p

Overview:
Parametrised successor to the fixed 8-bit counter/ROM/ALU chain. It steps a program counter through an external instruction memory and executes one ALU operation per instruction on a WIDTH-bit datapath. Each result is registered together with N/Z/C/V flags and delivered over a valid/ready handshake. A start/busy/done protocol controls each run, with optional looping and abort. It sits between the instruction memory and any downstream consumer or checker.

Parameters:
WIDTH, 8, datapath width in bits (>=2)
ADDR_W, 6, program counter width; instruction memory depth 2**ADDR_W
LOOP, 0, 1 = wrap to address 0 after last instruction and keep running; 0 = stop and pulse done

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin run at address 0; honoured only in IDLE
abort  in  1  synchronous; forces IDLE from any state
last_addr  in  ADDR_W  address of final instruction; sampled on accepted start
pc  out  ADDR_W  instruction address; instr is combinational from pc
instr  in  3+2*WIDTH  {op[2:0], A[WIDTH-1:0], B[WIDTH-1:0]}
res_data  out  WIDTH  registered result
res_flags  out  4  {N,Z,C,V} registered with res_data
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse at end of a non-looping run

Behaviour:
- Reset: IDLE, pc=0, res_data=0, res_flags=0, res_valid=0, busy=0, done=0, latched last_addr=0.
- States: IDLE, EXEC, WAIT, DONE.
- IDLE: busy=0. When start=1, set pc<=0, latch last_addr, go to EXEC.
- EXEC (1 cycle): decode instr at pc. Register res_data and res_flags, set res_valid<=1, go to WAIT.
- WAIT: hold res_valid, res_data, res_flags and pc stable while res_ready=0. On res_valid&res_ready: clear res_valid, then:
  - pc != last → pc<=pc+1, go to EXEC.
  - pc == last and LOOP=1 → pc<=0, go to EXEC.
  - pc == last and LOOP=0 → go to DONE.
- DONE: done=1 for exactly 1 cycle, busy=1, then go to IDLE. pc keeps last value.
- Latency: result valid 1 cycle after entering EXEC. Peak throughput 1 instruction per 2 cycles.
- start while busy: ignored.
- abort: highest priority after reset. Next edge: IDLE, res_valid=0, busy=0, no done pulse, pc and res_data keep last values. abort and start together in IDLE: abort wins.
- last_addr=0: single-instruction run.
- Ops, with R = WIDTH-bit result:
  - 000 add: R=A+B. C=carry out. V=signed overflow.
  - 001 sub: R=A+~B+1. C=carry out (1 = no borrow, i.e. A>=B unsigned). V=signed overflow.
  - 010 shl: R=A<<B. B>=WIDTH gives R=0. C=V=0.
  - 011 shr (logical): R=A>>B. B>=WIDTH gives R=0. C=V=0.
  - 100 and, 101 or, 110 xor: bitwise. C=V=0.
  - 111 not: R=~A, B ignored. C=V=0.
- Flags for all ops: N=R[WIDTH-1], Z=(R==0).
- Full B width is used as shift amount; no truncation modulo WIDTH.

Test Plan:
- WIDTH=8, single add 0xFF+0x01, last_addr=0 → res_data=0x00, flags N0 Z1 C1 V0, then done pulse 1 cycle, busy falls next cycle.
- sub 0x80-0x01 → 0x7F, N0 Z0 C1 V1. Then sub 0x01-0x02 → 0xFF, N1 Z0 C0 V0.
- shl 0x81 by 0x09 → 0x00 Z1. shr 0x80 by 0x03 → 0x10. shl 0x03 by 0x01 → 0x06. not 0x5A → 0xA5.
- res_ready low 5 cycles during WAIT → res_valid, res_data, flags and pc stable. On ready high: pc increments next edge, next result valid 2 cycles after handshake.
- last_addr=2, ready tied high. LOOP=0 → exactly 3 results (pc 0,1,2), then done pulse, start during run ignored. LOOP=1 → pc sequence 0,1,2,0,1 with no done.
- abort asserted in WAIT at pc=1 → next cycle IDLE, res_valid=0, busy=0, no done. Async reset mid-EXEC → all outputs zero immediately. Restart → pc=0.
